// File: rtl/morse_pkg.sv
// Shared Morse decode types and constants: FSM state codes, symbol encoding,
// timing multipliers and the ASCII codes emitted for word gaps and errors.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARK   = 2'd1,
    GAP    = 2'd2,
    WSPACE = 2'd3
  } morse_state_e;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Run lengths in units: dash/character threshold, stuck-key/word threshold.
  localparam int CHAR_MUL = 2;
  localparam int WORD_MUL = 5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ERR   = 8'h3F;

  typedef struct packed {
    logic [7:0] ascii;
    logic       err;
  } morse_char_t;

endpackage

// File: rtl/morse_decoder_if.sv
// Key line in, decoded character strobe out. The decoder takes the slave side;
// whatever drives the key line and consumes characters takes the master side.
interface morse_decoder_if;
  logic       key_in;
  logic [7:0] char_out;
  logic       char_valid;
  logic       error;

  modport master (output key_in, input char_out, input char_valid, input error);
  modport slave  (input key_in, output char_out, output char_valid, output error);
endinterface

// File: rtl/morse_lookup.sv
// Combinational Morse ROM: (len, pattern) -> ASCII for A-Z and 0-9.
// Symbols arrive MSB-first, so the first dot/dash is bit len-1 of pattern.
module morse_lookup #(
  parameter int MAX_SYMBOLS = 5
) (
  input  logic [2:0]             len,
  input  logic [MAX_SYMBOLS-1:0] pattern,
  output logic [7:0]             ascii,
  output logic                   hit
);
  localparam int PW = (MAX_SYMBOLS > 5) ? MAX_SYMBOLS : 5;

  logic [PW-1:0] pat;
  logic [PW+2:0] code;

  function automatic logic [PW+2:0] k(input int l, input int p);
    return {3'(l), PW'(p)};
  endfunction

  assign pat  = PW'(pattern);
  assign code = {len, pat};

  always_comb begin
    hit   = 1'b1;
    ascii = 8'h00;
    case (code)
      k(2, 'b01):    ascii = "A";
      k(4, 'b1000):  ascii = "B";
      k(4, 'b1010):  ascii = "C";
      k(3, 'b100):   ascii = "D";
      k(1, 'b0):     ascii = "E";
      k(4, 'b0010):  ascii = "F";
      k(3, 'b110):   ascii = "G";
      k(4, 'b0000):  ascii = "H";
      k(2, 'b00):    ascii = "I";
      k(4, 'b0111):  ascii = "J";
      k(3, 'b101):   ascii = "K";
      k(4, 'b0100):  ascii = "L";
      k(2, 'b11):    ascii = "M";
      k(2, 'b10):    ascii = "N";
      k(3, 'b111):   ascii = "O";
      k(4, 'b0110):  ascii = "P";
      k(4, 'b1101):  ascii = "Q";
      k(3, 'b010):   ascii = "R";
      k(3, 'b000):   ascii = "S";
      k(1, 'b1):     ascii = "T";
      k(3, 'b001):   ascii = "U";
      k(4, 'b0001):  ascii = "V";
      k(3, 'b011):   ascii = "W";
      k(4, 'b1001):  ascii = "X";
      k(4, 'b1011):  ascii = "Y";
      k(4, 'b1100):  ascii = "Z";
      k(5, 'b11111): ascii = "0";
      k(5, 'b01111): ascii = "1";
      k(5, 'b00111): ascii = "2";
      k(5, 'b00011): ascii = "3";
      k(5, 'b00001): ascii = "4";
      k(5, 'b00000): ascii = "5";
      k(5, 'b10000): ascii = "6";
      k(5, 'b11000): ascii = "7";
      k(5, 'b11100): ascii = "8";
      k(5, 'b11110): ascii = "9";
      default:       hit   = 1'b0;
    endcase
  end
endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: measures key mark/space runs, assembles dots/dashes and
// strobes the decoded ASCII on a character gap. Define MORSE_DEC_WORDSPACE_EN
// to also emit 8'h20 on word gaps.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1,
  parameter int MAX_SYMBOLS = 5
) (
  input logic            clock,
  input logic            reset,
  morse_decoder_if.slave bus
);
  localparam int CW = $clog2(5*UNIT_CYCLES+1);
  localparam logic [CW-1:0] CHAR_CNT = CW'(CHAR_MUL*UNIT_CYCLES);
  localparam logic [CW-1:0] LONG_CNT = CW'(WORD_MUL*UNIT_CYCLES);
  localparam logic [2:0]    MAX_LEN  = 3'(MAX_SYMBOLS);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_MARK   = MARK;
  localparam logic [1:0] ST_GAP    = GAP;
`ifdef MORSE_DEC_WORDSPACE_EN
  localparam logic [1:0] ST_WSPACE = WSPACE;
`endif

  logic [1:0]             state;
  logic                   key_q;
  logic [CW-1:0]          cnt;
  logic [MAX_SYMBOLS-1:0] pattern;
  logic [2:0]             len;
  logic                   bad;
  logic [7:0]             char_q;
  logic                   valid_q;
  logic                   err_q;

  logic [CW-1:0] cnt_inc;
  logic          sym;
  logic [7:0]    lk_ascii;
  logic          lk_hit;
  morse_char_t   dec;

  morse_lookup #(.MAX_SYMBOLS(MAX_SYMBOLS)) u_lookup (
    .len     (len),
    .pattern (pattern),
    .ascii   (lk_ascii),
    .hit     (lk_hit)
  );

  assign cnt_inc   = cnt + CW'(1);
  assign sym       = (cnt >= CHAR_CNT) ? SYM_DASH : SYM_DOT;
  assign dec.err   = bad | ~lk_hit;
  assign dec.ascii = dec.err ? ASCII_ERR : lk_ascii;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      key_q   <= 1'b1;
      cnt     <= '0;
      pattern <= '0;
      len     <= '0;
      bad     <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      key_q   <= bus.key_in;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // key_q resets high so a key held through reset is not a mark
          if (bus.key_in && !key_q) begin
            state <= ST_MARK;
            cnt   <= CW'(1);
          end
        end
        ST_MARK: begin
          if (bus.key_in) begin
            if (cnt != LONG_CNT) cnt <= cnt_inc;
          end else begin
            if (len == MAX_LEN) begin
              bad <= 1'b1;
            end else begin
              pattern <= (pattern << 1) | MAX_SYMBOLS'(sym);
              len     <= len + 3'd1;
            end
            if (cnt >= LONG_CNT) bad <= 1'b1;
            state <= ST_GAP;
            cnt   <= CW'(1);
          end
        end
        ST_GAP: begin
          // a high sample wins over the threshold: the gap was intra-character
          if (bus.key_in) begin
            state <= ST_MARK;
            cnt   <= CW'(1);
          end else if (cnt_inc == CHAR_CNT) begin
            char_q  <= dec.ascii;
            valid_q <= 1'b1;
            err_q   <= dec.err;
            pattern <= '0;
            len     <= '0;
            bad     <= 1'b0;
`ifdef MORSE_DEC_WORDSPACE_EN
            state   <= ST_WSPACE;
            cnt     <= cnt_inc;
`else
            state   <= ST_IDLE;
            cnt     <= '0;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
`ifdef MORSE_DEC_WORDSPACE_EN
        ST_WSPACE: begin
          if (bus.key_in) begin
            state <= ST_MARK;
            cnt   <= CW'(1);
          end else if (cnt_inc == LONG_CNT) begin
            char_q  <= ASCII_SPACE;
            valid_q <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.char_out   = char_q;
  assign bus.char_valid = valid_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder at UNIT_CYCLES=1 and 4 with a strobe scoreboard.
module tb_morse_decoder;
  import morse_pkg::*;

  logic clock;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  morse_decoder_if b1 ();
  morse_decoder_if b4 ();

  morse_decoder #(.UNIT_CYCLES(1), .MAX_SYMBOLS(5)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  morse_decoder #(.UNIT_CYCLES(4), .MAX_SYMBOLS(5)) dut4 (.clock(clock), .reset(reset), .bus(b4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  morse_char_t q1[$];
  morse_char_t q4[$];
  logic prev1 = 1'b0;
  logic prev4 = 1'b0;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] c, input logic e);
    morse_char_t m;
    m.ascii = c;
    m.err   = e;
    if (sel == 4) q4.push_back(m); else q1.push_back(m);
  endtask

  task automatic push_space(input int sel);
`ifdef MORSE_DEC_WORDSPACE_EN
    push(sel, ASCII_SPACE, 1'b0);
`else
    if (sel < 0) push(sel, ASCII_SPACE, 1'b0);
`endif
  endtask

  task automatic strobe(input int sel, input logic v, input logic e, input logic [7:0] c,
                        input logic prev);
    morse_char_t m;
    if (e) chk("err_without_valid", {8'h00, v}, 9'h001);
    if (v) begin
      chk("back_to_back", {8'h00, prev}, 9'h000);
      n_total++;
      assert ((sel == 4 ? q4.size() : q1.size()) != 0) else begin
        n_bad++;
        $error("FAIL unexpected_strobe u%0d got=%h exp=none", sel, {c, e});
      end
      if ((sel == 4 ? q4.size() : q1.size()) != 0) begin
        m = (sel == 4) ? q4.pop_front() : q1.pop_front();
        chk(sel == 4 ? "char_u4" : "char_u1", {c, e}, m);
      end
    end
  endtask

  always @(negedge clock) begin
    strobe(1, b1.char_valid, b1.error, b1.char_out, prev1);
    strobe(4, b4.char_valid, b4.error, b4.char_out, prev4);
    prev1 = b1.char_valid;
    prev4 = b4.char_valid;
  end

  task automatic drive(input int sel, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 4) b4.key_in = v; else b1.key_in = v;
      @(negedge clock);
    end
  endtask

  // Marks with one-unit intra-character gaps; no trailing gap.
  task automatic sym(input int sel, input string s);
    int u;
    u = (sel == 4) ? 4 : 1;
    for (int i = 0; i < s.len(); i++) begin
      drive(sel, 1'b1, (s[i] == 8'h2D) ? 3*u : u);
      if (i != s.len() - 1) drive(sel, 1'b0, u);
    end
  endtask

  task automatic word(input string s, input logic [7:0] c, input logic e);
    push(1, c, e);
    push_space(1);
    sym(1, s);
    drive(1, 1'b0, 7);
  endtask

  initial begin
    reset     = 1'b1;
    b1.key_in = 1'b0;
    b4.key_in = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_u1", {b1.char_out, b1.char_valid}, 9'h000);
    chk("rst_u1_err", {8'h00, b1.error}, 9'h000);
    chk("rst_u4", {b4.char_out, b4.char_valid}, 9'h000);
    reset = 1'b0;
    drive(1, 1'b0, 2);

    // "T": strobe exactly at the 2nd low sample, one cycle wide
    push(1, "T", 1'b0);
    push_space(1);
    drive(1, 1'b1, 3);
    drive(1, 1'b0, 1);
    chk("t_lat_low1", {8'h00, b1.char_valid}, 9'h000);
    drive(1, 1'b0, 1);
    chk("t_lat_low2", {b1.char_out, b1.char_valid}, {8'h54, 1'b1});
    chk("t_err", {8'h00, b1.error}, 9'h000);
    drive(1, 1'b0, 1);
    chk("t_one_cycle", {8'h00, b1.char_valid}, 9'h000);
    chk("t_held", {b1.char_out, 1'b0}, {8'h54, 1'b0});
    drive(1, 1'b0, 4);

    // "TEST" with 3-unit character gaps, word gap at the end
    push(1, "T", 1'b0); push(1, "E", 1'b0); push(1, "S", 1'b0); push(1, "T", 1'b0);
    push_space(1);
    sym(1, "-");   drive(1, 1'b0, 3);
    sym(1, ".");   drive(1, 1'b0, 3);
    sym(1, "..."); drive(1, 1'b0, 3);
    sym(1, "-");   drive(1, 1'b0, 7);

    // too many symbols, stuck key (6 and exactly 5U), longest legal dash, 5-symbol codes
    word("......", ASCII_ERR, 1'b1);
    push(1, ASCII_ERR, 1'b1); push_space(1);
    drive(1, 1'b1, 6); drive(1, 1'b0, 7);
    push(1, ASCII_ERR, 1'b1); push_space(1);
    drive(1, 1'b1, 5); drive(1, 1'b0, 7);
    push(1, "T", 1'b0); push_space(1);
    drive(1, 1'b1, 4); drive(1, 1'b0, 7);
    word(".....", "5", 1'b0);
    word("-----", "0", 1'b0);
    word("--.-", "Q", 1'b0);
    word("..-..", ASCII_ERR, 1'b1);

    // UNIT=4 ".-": strobe at the 8th low sample
    push(4, "A", 1'b0);
    push_space(4);
    sym(4, ".-");
    drive(4, 1'b0, 7);
    chk("a_u4_low7", {8'h00, b4.char_valid}, 9'h000);
    drive(4, 1'b0, 1);
    chk("a_u4_low8", {b4.char_out, b4.char_valid}, {8'h41, 1'b1});
    drive(4, 1'b0, 13);

    // reset during the 2nd dot of "S", released with key still high
    drive(1, 1'b1, 1);
    drive(1, 1'b0, 1);
    b1.key_in = 1'b1;
    reset     = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("mid_rst", {b1.char_out, b1.char_valid}, 9'h000);
    reset = 1'b0;
    drive(1, 1'b1, 2);
    drive(1, 1'b0, 10);
    word(".", "E", 1'b0);

    chk("missing_u1", 9'(q1.size()), 9'h000);
    chk("missing_u4", 9'(q4.size()), 9'h000);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
